core_ldst_misc_exec: RTL
========================

Name: core_ldst_misc_exec

Overview:
Execution sequencer for the misc load/store class: LDRH, STRH, LDRSB and LDRSH.
- Consumes the ldst_decode record plus the offset selection (off_is_imm, off_imm, off_reg value) produced by the misc load/store decoder.
- Computes the effective address and drives one bus transaction.
- Extracts and extends load data, then sequences register writebacks (base and/or Rd) to the register file port.
- Sits between decode/operand-read and the core's data bus master.

Parameters:
None. Data width is fixed at 32 by the word type; register numbers use the reg_num type.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  accept a new op; honoured only when ready=1
ready  out  1  idle, can accept start
decode  in  ldst_decode  decoded op; uses rn, rd, size, load, increment, writeback, sign_extend, pre_indexed
off_is_imm  in  1  offset is off_imm, otherwise rm_value
off_imm  in  8  immediate offset, zero-extended
rn_value  in  32  base register value
rm_value  in  32  offset register value
rd_value  in  32  store data
mem_start  out  1  one-cycle bus request pulse
mem_write  out  1  1=store
mem_addr  out  30  word address (addr[31:2])
mem_data_wr  out  32  store data, lane-replicated
mem_data_be  out  4  byte enables
mem_ready  in  1  bus completion; load data valid this cycle
mem_data_rd  in  32  load data
wb_en  out  1  register write strobe
wb_reg  out  reg_num  register to write
wb_value  out  32  value to write
done  out  1  one-cycle completion pulse
fault  out  1  alignment fault pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, all other outputs 0, latched operands cleared. Any bus response arriving after reset is ignored.
- Operand latch: on start&&ready, latch decode, rn_value, rm_value, rd_value and the offset. start while ready=0 is ignored.
- Address arithmetic:
  - off = off_is_imm ? {24'b0, off_imm} : rm_value.
  - upd = increment ? rn+off : rn-off, mod 2^32 wrap.
  - ea = pre_indexed ? upd : rn.
- Lane handling (ea[1:0]):
  - Half: be = ea[1] ? 1100 : 0011.
  - Byte: be = 0001 << ea[1:0].
  - Store data: halfword replicated to both halves; byte replicated to all four lanes.
- Load extract: select the lane(s) by ea[1:0]; sign-extend if sign_extend, else zero-extend. sign_extend is ignored on stores.
- FSM:
  - IDLE: start -> ISSUE.
  - ISSUE (1 cycle): mem_start=1, mem_addr=ea[31:2], mem_write=!load, be and data valid -> WAIT.
  - WAIT: hold mem_addr, mem_write, be and data until mem_ready. On mem_ready, latch extracted data. Next state is WB_BASE if base writeback is needed, else WB_DATA if load, else FIN. mem_ready in the same cycle as mem_start is not possible; the bus responds no earlier than the next cycle.
  - WB_BASE (1 cycle): wb_en=1, wb_reg=rn, wb_value=upd. Next is WB_DATA if load, else FIN.
  - WB_DATA (1 cycle): wb_en=1, wb_reg=rd, wb_value=extracted data -> FIN.
  - FIN (1 cycle): done=1 -> IDLE, ready=1 again.
- Base writeback condition: writeback && !(load && rd==rn). When loading into the base register, the loaded data wins.
- Minimum latency, start to done, with single-cycle bus: store without writeback = 4 cycles; load with writeback = 6 cycles.
- wb_en is never high outside WB_BASE or WB_DATA. mem_start is never high outside ISSUE.

Optional Feature:
CORE_LDST_MISC_ALIGN_FAULT_EN
- Defined: in ISSUE, a halfword op with ea[0]=1 raises fault for 1 cycle instead of mem_start, with no bus access and no writebacks, then goes to FIN (done=1).
- Undefined: fault tied 0 and ea[0] is forced to 0 for halfword ops, so the access is rounded down.

Decomposition:
- The ldst_decode record and the ldst_size enum (LDST_BYTE/LDST_HALF) come from the shared uarch package.
- Add to the uarch package: the FSM state enum ldst_misc_state and a ldst_lane_be helper function.
- One sub-module: core_ldst_misc_lane, pure combinational. It takes size, ea[1:0], sign_extend, rd_value and mem_data_rd, and produces be, mem_data_wr and the extracted load value.

Test Plan:
- LDRH, pre-indexed, imm=4, U=1, W=0, rn=0x1000, mem word 0xBEEF1234 -> mem_addr=0x401, be=0011, one writeback r_rd=0x00001234, done 5 cycles after start.
- LDRSB, post-indexed, reg offset rm=3, U=0, rn=0x2003, byte lane3=0x80 -> ea=0x2003, be=1000, writebacks rn=0x2000 then rd=0xFFFFFF80.
- STRH, pre-indexed with W=1, imm=2, rn=0x3000, rd=0xAAAA5678 -> be=1100, mem_data_wr=0x56785678, mem_write=1, single writeback rn=0x3002.
- LDRH with rd==rn, writeback=1 -> only the data writeback occurs. mem_ready delayed 5 cycles -> addr, be and data held stable throughout.
- rst_n pulsed low during WAIT -> ready=1 and all outputs 0 immediately; a late mem_ready produces no writeback and no done.
- With CORE_LDST_MISC_ALIGN_FAULT_EN, LDRSH at ea=0x1001 -> fault=1, no mem_start, no wb_en, then done. Without the macro -> access at mem_addr=0x400, be=0011.

Source files
------------

// File: rtl/core_ldst_misc_exec_pkg.sv
// core_ldst_misc_exec_pkg: shared uarch types for the misc load/store (LDRH/STRH/LDRSB/LDRSH) path
package core_ldst_misc_exec_pkg;

    typedef logic [31:0] word;
    typedef logic [3:0]  reg_num;

    typedef enum logic { LDST_BYTE, LDST_HALF } ldst_size;

    typedef struct packed {
        reg_num   rn;
        reg_num   rd;
        ldst_size size;
        logic     load;
        logic     increment;
        logic     writeback;
        logic     sign_extend;
        logic     pre_indexed;
    } ldst_decode;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB_BASE,
        ST_WB_DATA,
        ST_FIN
    } ldst_misc_state;

    function automatic logic [3:0] ldst_lane_be(ldst_size size, logic [1:0] ea_lo);
        return size == LDST_HALF ? (ea_lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ea_lo;
    endfunction

endpackage

// File: rtl/core_ldst_misc_exec_lane.sv
// core_ldst_misc_exec_lane: byte enables, store replication and load extraction/extension
module core_ldst_misc_exec_lane
    import core_ldst_misc_exec_pkg::*;
(
    input  ldst_size    size,
    input  logic [1:0]  ea_lo,
    input  logic        sign_extend,
    input  logic [31:0] rd_value,
    input  logic [31:0] mem_data_rd,
    output logic [3:0]  be,
    output logic [31:0] wr_data,
    output logic [31:0] rd_ext
);

    logic        half;
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    assign half    = size == LDST_HALF;
    assign be      = ldst_lane_be(size, ea_lo);
    assign wr_data = half ? {2{rd_value[15:0]}} : {4{rd_value[7:0]}};
    assign half_v  = ea_lo[1] ? mem_data_rd[31:16] : mem_data_rd[15:0];
    assign byte_v  = mem_data_rd[{ea_lo, 3'b000} +: 8];
    assign rd_ext  = half ? {{16{sign_extend & half_v[15]}}, half_v}
                          : {{24{sign_extend & byte_v[7]}}, byte_v};

endmodule

// File: rtl/core_ldst_misc_exec.sv
// core_ldst_misc_exec: misc load/store sequencer (EA, one bus access, base/Rd writebacks)
// CORE_LDST_MISC_ALIGN_FAULT_EN: fault odd halfword accesses instead of rounding them down
module core_ldst_misc_exec
    import core_ldst_misc_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ready,
    input  ldst_decode  decode,
    input  logic        off_is_imm,
    input  logic [7:0]  off_imm,
    input  logic [31:0] rn_value,
    input  logic [31:0] rm_value,
    input  logic [31:0] rd_value,
    output logic        mem_start,
    output logic        mem_write,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_wr,
    output logic [3:0]  mem_data_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_data_rd,
    output logic        wb_en,
    output reg_num      wb_reg,
    output logic [31:0] wb_value,
    output logic        done,
    output logic        fault
);

    ldst_misc_state state, state_nx;
    ldst_decode     dec_q;
    word            rn_q, off_q, rd_q, data_q;
    word            upd, ea_raw, ea, wr_data, rd_ext;
    logic [3:0]     be;
    logic           half, align_err, base_wb, bus;

    assign half    = dec_q.size == LDST_HALF;
    assign upd     = dec_q.increment ? rn_q + off_q : rn_q - off_q;
    assign ea_raw  = dec_q.pre_indexed ? upd : rn_q;
    assign base_wb = dec_q.writeback && !(dec_q.load && dec_q.rd == dec_q.rn);

`ifdef CORE_LDST_MISC_ALIGN_FAULT_EN
    assign ea        = ea_raw;
    assign align_err = half && ea_raw[0];
`else
    assign ea        = {ea_raw[31:1], ea_raw[0] & ~half};
    assign align_err = 1'b0;
`endif

    core_ldst_misc_exec_lane u_lane (
        .size       (dec_q.size),
        .ea_lo      (ea[1:0]),
        .sign_extend(dec_q.sign_extend),
        .rd_value   (rd_q),
        .mem_data_rd(mem_data_rd),
        .be         (be),
        .wr_data    (wr_data),
        .rd_ext     (rd_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            dec_q  <= '0;
            rn_q   <= '0;
            off_q  <= '0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (start && ready) begin
                dec_q <= decode;
                rn_q  <= rn_value;
                off_q <= off_is_imm ? {24'b0, off_imm} : rm_value;
                rd_q  <= rd_value;
            end
            if (state == ST_WAIT && mem_ready)
                data_q <= rd_ext;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    state_nx = start ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:   state_nx = align_err ? ST_FIN : ST_WAIT;
            ST_WAIT:    state_nx = !mem_ready ? ST_WAIT : base_wb ? ST_WB_BASE
                                 : dec_q.load ? ST_WB_DATA : ST_FIN;
            ST_WB_BASE: state_nx = dec_q.load ? ST_WB_DATA : ST_FIN;
            ST_WB_DATA: state_nx = ST_FIN;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Bus outputs are gated to ISSUE/WAIT so they read 0 whenever no access is in flight
    assign bus         = (state == ST_ISSUE && !align_err) || state == ST_WAIT;
    assign ready       = state == ST_IDLE;
    assign done        = state == ST_FIN;
    assign fault       = state == ST_ISSUE && align_err;
    assign mem_start   = state == ST_ISSUE && !align_err;
    assign mem_write   = bus && !dec_q.load;
    assign mem_addr    = bus ? ea[31:2] : '0;
    assign mem_data_be = bus ? be : '0;
    assign mem_data_wr = bus ? wr_data : '0;
    assign wb_en       = state == ST_WB_BASE || state == ST_WB_DATA;
    assign wb_reg      = state == ST_WB_BASE ? dec_q.rn : state == ST_WB_DATA ? dec_q.rd : '0;
    assign wb_value    = state == ST_WB_BASE ? upd : state == ST_WB_DATA ? data_q : '0;

endmodule
